// File: rtl/native_bus_timer_pkg.sv
// Shared definitions for the native-bus timer: register offsets,
// control/status bit positions and a byte-lane merge helper.
package native_bus_timer_pkg;

    localparam logic [4:0] REG_CTRL     = 5'h00;
    localparam logic [4:0] REG_PRESCALE = 5'h04;
    localparam logic [4:0] REG_COUNT    = 5'h08;
    localparam logic [4:0] REG_COMPARE  = 5'h0C;
    localparam logic [4:0] REG_STATUS   = 5'h10;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_RELOAD  = 1;
    localparam int CTRL_IE      = 2;
    localparam int STATUS_MATCH = 0;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [3:0]  wstrb
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/native_bus_timer_prescaler.sv
// Prescaler: free-runs while enabled and emits a one-cycle tick
// whenever its counter equals the programmed divide value.
module timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pre_cnt;

    assign tick = en && (pre_cnt == prescale);

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/native_bus_timer.sv
// Memory-mapped 32-bit timer on the picorv32 native bus with
// prescaler, compare match, auto-reload and a level interrupt.
module native_bus_timer
    import native_bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        irq
);

    logic [2:0]            ctrl, ctrl_n;
    logic [PRESCALE_W-1:0] prescale, prescale_n;
    logic [31:0]           count, count_n;
    logic [31:0]           compare, compare_n;
    logic                  match, match_n;
    logic [31:0]           prescale_w;
    logic [31:0]           rd_mux;
    logic [4:0]            off;
    logic                  sel, access, wr, tick, hit;
    logic                  unused_bits;

    assign sel    = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
    assign access = sel && !mem_ready;
    assign wr     = access && (mem_wstrb != 4'b0000);
    assign off    = {mem_addr[4:2], 2'b00};
    assign hit    = tick && (count == compare);

    assign unused_bits = ^{mem_addr[1:0], prescale_w};

    timer_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en      (ctrl[CTRL_EN]),
        .prescale(prescale),
        .tick    (tick)
    );

    always_comb begin
        rd_mux = '0;
        case (off)
            REG_CTRL:     rd_mux = {29'b0, ctrl};
            REG_PRESCALE: rd_mux = 32'(prescale);
            REG_COUNT:    rd_mux = count;
            REG_COMPARE:  rd_mux = compare;
            REG_STATUS:   rd_mux = {31'b0, match};
            default:      rd_mux = '0;
        endcase
    end

    // Timer effects first; CPU writes then override the bytes they touch,
    // except a STATUS clear, which loses to a match on the same edge.
    always_comb begin
        ctrl_n     = ctrl;
        prescale_n = prescale;
        count_n    = count;
        compare_n  = compare;
        match_n    = match;
        prescale_w = merge_bytes(32'(prescale), mem_wdata, mem_wstrb);
        if (hit) begin
            match_n = 1'b1;
            if (ctrl[CTRL_RELOAD]) begin
                count_n = '0;
            end else begin
                ctrl_n[CTRL_EN] = 1'b0;
            end
        end else if (tick) begin
            count_n = count + 32'd1;
        end
        if (wr) begin
            case (off)
                REG_CTRL: begin
                    if (mem_wstrb[0]) begin
                        ctrl_n = mem_wdata[2:0];
                    end
                end
                REG_PRESCALE: prescale_n = prescale_w[PRESCALE_W-1:0];
                REG_COUNT:    count_n = merge_bytes(count_n, mem_wdata, mem_wstrb);
                REG_COMPARE:  compare_n = merge_bytes(compare, mem_wdata, mem_wstrb);
                REG_STATUS: begin
                    if (mem_wstrb[0] && mem_wdata[STATUS_MATCH] && !hit) begin
                        match_n = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl      <= '0;
            prescale  <= '0;
            count     <= '0;
            compare   <= '0;
            match     <= 1'b0;
            irq       <= 1'b0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            ctrl      <= ctrl_n;
            prescale  <= prescale_n;
            count     <= count_n;
            compare   <= compare_n;
            match     <= match_n;
            irq       <= match_n && ctrl_n[CTRL_IE];
            mem_ready <= access;
            mem_rdata <= access ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_native_bus_timer.sv
// Randomised and directed bench for native_bus_timer with a
// cycle-level reference model and a response scoreboard.
module tb_native_bus_timer;

    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_PS   = BASE + 32'h04;
    localparam logic [31:0] A_CNT  = BASE + 32'h08;
    localparam logic [31:0] A_CMP  = BASE + 32'h0C;
    localparam logic [31:0] A_STAT = BASE + 32'h10;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq[$];
    bit          dchk[$];
    logic [31:0] dexp[$];

    native_bus_timer dut (
        .clk      (clk),
        .reset    (reset),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_count, m_cmp;
    logic [15:0] m_ps;
    int unsigned m_pre;
    bit m_en, m_rl, m_ie, m_match, m_ready, m_irq;

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~mask) | (d & mask);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] v;
        v = 32'd0;
        if (a[4:2] == 3'd0) v = {29'd0, m_ie, m_rl, m_en};
        if (a[4:2] == 3'd1) v = {16'd0, m_ps};
        if (a[4:2] == 3'd2) v = m_count;
        if (a[4:2] == 3'd3) v = m_cmp;
        if (a[4:2] == 3'd4) v = {31'd0, m_match};
        return v;
    endfunction

    always @(posedge clk) begin : model
        bit acc, tick, hit, nen, nm;
        logic [31:0] nc, tmp;
        if (reset) begin
            m_count = 0; m_cmp = 0; m_ps = 0; m_pre = 0;
            m_en = 0; m_rl = 0; m_ie = 0; m_match = 0;
            m_ready = 0; m_irq = 0;
        end else begin
            acc  = mem_valid && (mem_addr[31:5] == BASE[31:5]) && !m_ready;
            tick = m_en && (m_pre == 32'(m_ps));
            hit  = tick && (m_count == m_cmp);
            if (acc) mq.push_back(model_read(mem_addr));
            nc = m_count; nen = m_en; nm = m_match;
            if (hit) begin
                nm = 1;
                if (m_rl) nc = 0;
                else nen = 0;
            end else if (tick) begin
                nc = m_count + 1;
            end
            m_pre = (!m_en || tick) ? 0 : (m_pre + 1) % 65536;
            if (acc && mem_wstrb != 4'd0) begin
                case (mem_addr[4:2])
                    3'd0: if (mem_wstrb[0]) begin
                        nen = mem_wdata[0]; m_rl = mem_wdata[1]; m_ie = mem_wdata[2];
                    end
                    3'd1: begin
                        tmp = lanes({16'd0, m_ps}, mem_wdata, mem_wstrb);
                        m_ps = tmp[15:0];
                    end
                    3'd2: nc = lanes(nc, mem_wdata, mem_wstrb);
                    3'd3: m_cmp = lanes(m_cmp, mem_wdata, mem_wstrb);
                    3'd4: if (mem_wstrb[0] && mem_wdata[0] && !hit) nm = 0;
                    default: ;
                endcase
            end
            m_count = nc; m_en = nen; m_match = nm;
            m_irq = nm && m_ie;
            m_ready = acc;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin : monitor
        logic [31:0] e, x;
        bit c;
        e = 32'd0;
        checks++;
        if (mem_ready !== m_ready) begin
            errors++;
            $display("FAIL ready: got %b expected %b t=%0t", mem_ready, m_ready, $time);
        end
        checks++;
        if (irq !== m_irq) begin
            errors++;
            $display("FAIL irq: got %b expected %b t=%0t", irq, m_irq, $time);
        end
        if (mem_ready === 1'b1) begin
            if (mq.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty: unexpected response t=%0t", $time);
            end else begin
                e = mq.pop_front();
            end
            if (dchk.size() > 0) begin
                c = dchk.pop_front();
                x = dexp.pop_front();
                if (c) begin
                    checks++;
                    if (mem_rdata !== x) begin
                        errors++;
                        $display("FAIL directed_rd: got %h expected %h t=%0t", mem_rdata, x, $time);
                    end
                end
            end
        end
        checks++;
        if (mem_rdata !== e) begin
            errors++;
            $display("FAIL rdata: got %h expected %h t=%0t", mem_rdata, e, $time);
        end
    end

    task automatic expect32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input bit chk, input logic [31:0] exp, output int n);
        bit got;
        dchk.push_back(chk);
        dexp.push_back(exp);
        mem_valid = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        got = 0; n = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            n = i + 1;
            got = mem_ready;
        end
        mem_valid = 0; mem_wstrb = 0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL handshake: no ready for addr %h", a);
            void'(dchk.pop_back());
            void'(dexp.pop_back());
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        int n;
        bus(a, d, 4'hF, 0, 0, n);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        int n;
        bus(a, 0, 4'h0, 1, exp, n);
    endtask

    task automatic outside(input logic [31:0] a);
        bit seen;
        seen = 0;
        mem_valid = 1; mem_addr = a; mem_wstrb = 4'h0;
        repeat (4) begin
            @(negedge clk);
            if (mem_ready) seen = 1;
        end
        mem_valid = 0;
        expect32("unselected_ready", {31'd0, seen}, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] a, d;
        logic [3:0] s;
        reset = 1; mem_valid = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
        repeat (3) @(negedge clk);
        reset = 0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus(BASE + 32'(4 * i), 0, 4'h0, 1, 32'd0, n);
            expect32("reset_latency", n, 1);
        end
        expect32("reset_irq", {31'd0, irq}, 0);

        // Periodic auto-reload with interrupt
        wr(A_PS, 3);
        wr(A_CMP, 5);
        wr(A_CTRL, 7);
        repeat (22) @(negedge clk);
        rd(A_STAT, 0);
        expect32("irq_before", {31'd0, irq}, 0);
        rd(A_STAT, 1);
        expect32("irq_after", {31'd0, irq}, 1);
        rd(A_CNT, 0);
        wr(A_STAT, 1);
        expect32("irq_cleared", {31'd0, irq}, 0);
        repeat (17) @(negedge clk);
        rd(A_STAT, 0);
        expect32("irq_before2", {31'd0, irq}, 0);
        @(negedge clk);
        expect32("irq_period", {31'd0, irq}, 1);
        rd(A_STAT, 1);
        for (int i = 0; i < 20; i++) begin
            bus(A_CNT, 0, 4'h0, 0, 0, n);
        end
        wr(A_CTRL, 0);
        wr(A_STAT, 1);

        // One-shot
        wr(A_CNT, 0);
        wr(A_PS, 0);
        wr(A_CMP, 2);
        wr(A_CTRL, 1);
        repeat (5) @(negedge clk);
        rd(A_CNT, 2);
        rd(A_CTRL, 0);
        rd(A_STAT, 1);
        wr(A_STAT, 1);

        // Wrap without match
        wr(A_CNT, 32'hFFFF_FFFE);
        wr(A_CMP, 5);
        wr(A_PS, 1);
        wr(A_CTRL, 1);
        rd(A_CNT, 32'hFFFF_FFFE);
        rd(A_CNT, 32'hFFFF_FFFF);
        rd(A_CNT, 32'h0);
        rd(A_STAT, 0);
        wr(A_CTRL, 0);

        // Byte strobes
        wr(A_CMP, 32'h1122_3344);
        bus(A_CMP, 32'h0000_AB00, 4'b0010, 0, 0, n);
        rd(A_CMP, 32'h1122_AB44);

        // Clear and set on the same edge
        wr(A_STAT, 1);
        wr(A_CNT, 0);
        wr(A_PS, 0);
        wr(A_CMP, 3);
        wr(A_CTRL, 3);
        repeat (3) @(negedge clk);
        wr(A_STAT, 1);
        rd(A_STAT, 1);
        wr(A_CTRL, 0);
        wr(A_STAT, 1);

        // Reserved offsets and foreign addresses
        wr(BASE + 32'h18, 32'hFFFF_FFFF);
        rd(BASE + 32'h14, 0);
        outside(BASE + 32'h20);

        // Random traffic checked against the model
        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                outside(BASE + 32'h20 + 32'($urandom_range(0, 7) << 2));
            end else begin
                a = BASE + 32'($urandom_range(0, 7) << 2);
                d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12));
                case ($urandom_range(0, 3))
                    0, 1:    s = 4'h0;
                    2:       s = 4'hF;
                    default: s = 4'($urandom_range(1, 15));
                endcase
                bus(a, d, s, 0, 0, n);
            end
        end

        // Reset during an in-flight request
        @(negedge clk);
        mem_valid = 1; mem_addr = A_CNT; mem_wstrb = 0; reset = 1;
        repeat (2) @(negedge clk);
        expect32("reset_ready", {31'd0, mem_ready}, 0);
        reset = 0; mem_valid = 0;
        @(negedge clk);
        rd(A_CTRL, 0);
        rd(A_CNT, 0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
